// File: rtl/senone_score_sequencer_if.sv
// rtl/senone_score_sequencer_if.sv - score RAM read port plus framed score stream
interface senone_score_sequencer_if #(
    parameter int ADDR_W  = 12,
    parameter int SCORE_W = 16
);
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [SCORE_W-1:0] rd_data;
    logic                      new_vector_available;
    logic                      new_senone;
    logic                      last_senone;
    logic signed [SCORE_W-1:0] current_score;
    logic [ADDR_W-1:0]         senone_index;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output new_vector_available, new_senone, last_senone, current_score, senone_index
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  new_vector_available, new_senone, last_senone, current_score, senone_index
    );
endinterface

// File: rtl/senone_score_sequencer.sv
// rtl/senone_score_sequencer.sv - reads one vector's senone scores from RAM and frames them for the max-finder
module senone_score_sequencer #(
    parameter int N_SENONES    = 4096,
    parameter int ADDR_W       = 12,
    parameter int SCORE_W      = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic busy,
    output logic done,
    senone_score_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SENONES - 1);

    state_t                state;
    logic [ADDR_W-1:0]     addr_cnt;
    logic [READ_LATENCY:1] pipe_valid;
    logic [ADDR_W-1:0]     pipe_addr [1:READ_LATENCY];
    logic                  issue;

    // Reads go out in CLEAR as well so the first address leaves the cycle after the clear pulse.
    assign issue = ((state == CLEAR) || (state == ISSUE)) && !hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= IDLE;
            addr_cnt                 <= '0;
            pipe_valid               <= '0;
            for (int i = 1; i <= READ_LATENCY; i++) pipe_addr[i] <= '0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
            bus.rd_en                <= 1'b0;
            bus.rd_addr              <= '0;
            bus.new_vector_available <= 1'b0;
            bus.new_senone           <= 1'b0;
            bus.last_senone          <= 1'b0;
            bus.current_score        <= '0;
            bus.senone_index         <= '0;
        end else begin
            bus.rd_en                <= 1'b0;
            bus.new_vector_available <= 1'b0;
            bus.new_senone           <= 1'b0;
            bus.last_senone          <= 1'b0;
            done                     <= 1'b0;

            // Stage 1 tracks the read on the RAM port now; stage READ_LATENCY lines up with rd_data.
            pipe_valid[1] <= bus.rd_en;
            pipe_addr[1]  <= bus.rd_addr;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end

            if (pipe_valid[READ_LATENCY]) begin
                bus.new_senone    <= 1'b1;
                bus.current_score <= bus.rd_data;
                bus.senone_index  <= pipe_addr[READ_LATENCY];
                bus.last_senone   <= (pipe_addr[READ_LATENCY] == LAST_ADDR);
            end

            if (issue) begin
                bus.rd_en   <= 1'b1;
                bus.rd_addr <= addr_cnt;
                if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state                    <= CLEAR;
                        bus.new_vector_available <= 1'b1;
                        busy                     <= 1'b1;
                        addr_cnt                 <= '0;
                    end
                end
                CLEAR: begin
                    state <= (issue && addr_cnt == LAST_ADDR) ? DRAIN : ISSUE;
                end
                ISSUE: begin
                    if (issue && addr_cnt == LAST_ADDR) state <= DRAIN;
                end
                DRAIN: begin
                    // Reads return in order, so the final index emerging means nothing is left in flight.
                    if (bus.last_senone) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_senone_score_sequencer.sv
// tb/tb_senone_score_sequencer.sv - three-configuration bench with cycle-schedule model and literal pins
module tb_senone_score_sequencer;
    localparam int MAXC = 300;

    logic clk = 1'b0;
    logic reset, start, hold;
    logic [2:0] busy_o, done_o;

    always #5 clk = ~clk;

    senone_score_sequencer_if #(.ADDR_W(2), .SCORE_W(16)) if0 ();
    senone_score_sequencer_if #(.ADDR_W(2), .SCORE_W(16)) if1 ();
    senone_score_sequencer_if #(.ADDR_W(1), .SCORE_W(16)) if2 ();

    senone_score_sequencer #(.N_SENONES(4), .ADDR_W(2), .SCORE_W(16), .READ_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .busy(busy_o[0]), .done(done_o[0]), .bus(if0.master));
    senone_score_sequencer #(.N_SENONES(4), .ADDR_W(2), .SCORE_W(16), .READ_LATENCY(3)) u1 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .busy(busy_o[1]), .done(done_o[1]), .bus(if1.master));
    senone_score_sequencer #(.N_SENONES(2), .ADDR_W(1), .SCORE_W(16), .READ_LATENCY(1)) u2 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .busy(busy_o[2]), .done(done_o[2]), .bus(if2.master));

    // ctl bits: [5] new_vector_available [4] new_senone [3] last_senone [2] done [1] busy [0] rd_en
    logic [5:0]         o_ctl   [3];
    logic [31:0]        o_addr  [3];
    logic [31:0]        o_idx   [3];
    logic signed [15:0] o_score [3];

    assign o_ctl[0] = {if0.new_vector_available, if0.new_senone, if0.last_senone, done_o[0], busy_o[0], if0.rd_en};
    assign o_ctl[1] = {if1.new_vector_available, if1.new_senone, if1.last_senone, done_o[1], busy_o[1], if1.rd_en};
    assign o_ctl[2] = {if2.new_vector_available, if2.new_senone, if2.last_senone, done_o[2], busy_o[2], if2.rd_en};
    assign o_addr[0] = 32'(if0.rd_addr);
    assign o_addr[1] = 32'(if1.rd_addr);
    assign o_addr[2] = 32'(if2.rd_addr);
    assign o_idx[0]  = 32'(if0.senone_index);
    assign o_idx[1]  = 32'(if1.senone_index);
    assign o_idx[2]  = 32'(if2.senone_index);
    assign o_score[0] = if0.current_score;
    assign o_score[1] = if1.current_score;
    assign o_score[2] = if2.current_score;

    int n_p  [3] = '{4, 4, 2};
    int rl_p [3] = '{1, 3, 1};
    logic signed [15:0] ram [3][4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Expected outputs per configuration, indexed by absolute cycle number.
    bit [5:0]  e_ctl   [3][MAXC];
    int        e_addr  [3][MAXC];
    int        e_idx   [3][MAXC];
    bit [15:0] e_score [3][MAXC];

    bit m_on [3];
    int m_start [3];
    int m_issued [3];
    int m_done [3];

    // Frame schedule: accepted start at s -> clear pulse s+1; a read goes out in c+1 whenever hold was low
    // in cycle c >= s+1; each read emerges READ_LATENCY+1 cycles after issue; done one cycle after the last.
    initial begin
        for (int d = 0; d < 3; d++) begin
            m_on[d] = 1'b0; m_done[d] = -1; m_issued[d] = 0; m_start[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                if (reset) begin
                    m_on[d] = 1'b0;
                    for (int k = cyc + 1; k < MAXC; k++) e_ctl[d][k] = '0;
                end else begin
                    if (m_on[d] && m_done[d] >= 0 && cyc > m_done[d]) m_on[d] = 1'b0;
                    if (!m_on[d] && start) begin
                        m_on[d] = 1'b1; m_start[d] = cyc; m_issued[d] = 0; m_done[d] = -1;
                        if (cyc + 1 < MAXC) e_ctl[d][cyc+1][5] = 1'b1;
                    end else if (m_on[d] && m_issued[d] < n_p[d] && !hold) begin
                        int k;
                        k = cyc + 2 + rl_p[d];
                        if (k + 1 < MAXC) begin
                            e_ctl[d][cyc+1][0] = 1'b1;
                            e_addr[d][cyc+1]   = m_issued[d];
                            e_ctl[d][k][4]     = 1'b1;
                            e_idx[d][k]        = m_issued[d];
                            e_score[d][k]      = ram[d][m_issued[d]];
                            if (m_issued[d] == n_p[d] - 1) begin
                                e_ctl[d][k][3]   = 1'b1;
                                e_ctl[d][k+1][2] = 1'b1;
                                m_done[d]        = k + 1;
                            end
                        end
                        m_issued[d]++;
                    end
                    if (cyc + 1 < MAXC)
                        e_ctl[d][cyc+1][1] = m_on[d] && (m_done[d] < 0 || cyc + 1 < m_done[d]);
                end
            end
            cyc++;
        end
    end

    // Score RAM: read data for a read issued in cycle t is presented during cycle t+READ_LATENCY.
    int rq [3][4];
    function automatic logic signed [15:0] ram_out(int d);
        int a;
        a = rq[d][rl_p[d]];
        return (a >= 0) ? ram[d][a] : 16'sh5A5A;
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) for (int i = 0; i < 4; i++) rq[d][i] = -1;
        if0.rd_data = '0; if1.rd_data = '0; if2.rd_data = '0;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                for (int i = 3; i > 0; i--) rq[d][i] = rq[d][i-1];
                rq[d][0] = (o_ctl[d][0] === 1'b1) ? int'(o_addr[d]) : -1;
            end
            if0.rd_data = ram_out(0);
            if1.rd_data = ram_out(1);
            if2.rd_data = ram_out(2);
        end
    end

    int nva_cnt [3];
    int ns_cnt [3];
    int first_ns [3];
    int best [3];
    int done_cyc [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            nva_cnt[d] = 0; ns_cnt[d] = 0; first_ns[d] = -1; best[d] = -65536; done_cyc[d] = -1;
        end
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < MAXC) begin
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (o_ctl[d] !== e_ctl[d][cyc]) begin
                        errors++;
                        $display("FAIL ctl dut%0d cyc=%0d got=%b want=%b", d, cyc, o_ctl[d], e_ctl[d][cyc]);
                    end
                    if (e_ctl[d][cyc][0]) begin
                        checks++;
                        if (o_addr[d] !== 32'(e_addr[d][cyc])) begin
                            errors++;
                            $display("FAIL rd_addr dut%0d cyc=%0d got=%0d want=%0d", d, cyc, o_addr[d], e_addr[d][cyc]);
                        end
                    end
                    if (e_ctl[d][cyc][4]) begin
                        checks++;
                        if (o_score[d] !== e_score[d][cyc] || o_idx[d] !== 32'(e_idx[d][cyc])) begin
                            errors++;
                            $display("FAIL score dut%0d cyc=%0d got=%h@%0d want=%h@%0d", d, cyc,
                                     o_score[d], o_idx[d], e_score[d][cyc], e_idx[d][cyc]);
                        end
                    end
                    if (o_ctl[d][5] === 1'b1) begin
                        nva_cnt[d]++; ns_cnt[d] = 0; first_ns[d] = -1; best[d] = -65536;
                    end
                    if (o_ctl[d][4] === 1'b1) begin
                        ns_cnt[d]++;
                        if (first_ns[d] < 0) first_ns[d] = cyc;
                        if (int'(o_score[d]) > best[d]) best[d] = int'(o_score[d]);
                    end
                    if (o_ctl[d][2] === 1'b1) done_cyc[d] = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic zero_check(input string name);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_ctl[d] !== 6'b0 || o_score[d] !== 16'sh0 || o_idx[d] !== 32'h0 || o_addr[d] !== 32'h0) begin
                errors++;
                $display("FAIL %s dut%0d got ctl=%b score=%h idx=%0d addr=%0d want all 0", name, d,
                         o_ctl[d], o_score[d], o_idx[d], o_addr[d]);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Bit i of each mask drives that input during cycle S+i.
    task automatic run(input logic [63:0] smask, input logic [63:0] hmask, input logic [63:0] rmask, input int n);
        for (int i = 0; i < n; i++) begin
            start = smask[i]; hold = hmask[i]; reset = rmask[i];
            tick;
        end
        start = 1'b0; hold = 1'b0; reset = 1'b0;
    endtask

    int s;

    initial begin
        ram[0] = '{16'sd5, -16'sd3, 16'sd12, 16'sd7};
        ram[1] = '{16'sh8000, 16'sh8001, -16'sd1, 16'sd0};
        ram[2] = '{16'sd100, -16'sd100, 16'sd0, 16'sd0};
        reset = 1'b1; start = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        tick;
        reset = 1'b0;
        zero_check("reset_state");
        tick;

        s = cyc;
        run(64'h1, 64'h0, 64'h0, 20);
        chk("plain_first_ns_l1", first_ns[0] - s, 4);
        chk("plain_done_l1", done_cyc[0] - s, 8);
        chk("plain_count_l1", ns_cnt[0], 4);
        chk("plain_best_l1", best[0], 12);
        chk("plain_first_ns_l3", first_ns[1] - s, 6);
        chk("plain_best_l3", best[1], 0);
        chk("plain_done_n2", done_cyc[2] - s, 6);
        chk("plain_count_n2", ns_cnt[2], 2);
        chk("plain_best_n2", best[2], 100);

        s = cyc;
        run(64'h1, 64'h38, 64'h0, 20);
        chk("hold_done_l1", done_cyc[0] - s, 11);
        chk("hold_count_l1", ns_cnt[0], 4);
        chk("hold_best_l1", best[0], 12);

        for (int d = 0; d < 3; d++) nva_cnt[d] = 0;
        s = cyc;
        run(64'h309, 64'h0, 64'h0, 40);
        chk("restart_frames_l1", nva_cnt[0], 2);
        chk("restart_frames_l3", nva_cnt[1], 1);
        chk("restart_frames_n2", nva_cnt[2], 2);
        chk("restart_count_l1", ns_cnt[0], 4);

        for (int d = 0; d < 3; d++) nva_cnt[d] = 0;
        s = cyc;
        run(64'h1, 64'h0, 64'h40, 7);
        zero_check("after_abort");
        run(64'h20, 64'h0, 64'h0, 25);
        chk("abort_then_frames_l1", nva_cnt[0], 2);
        chk("abort_then_count_l1", ns_cnt[0], 4);
        chk("abort_then_best_l1", best[0], 12);
        chk("abort_then_done_l1", done_cyc[0] - s, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/senone_score_sequencer.md
Name: senone_score_sequencer

Overview:
- Producer side of the score/maximum interface. The max-finder consumes this stream; this block drives it.
- On each new feature vector, it reads N_SENONES scores from the senone score RAM in address order.
- It frames the read-back scores as a stream for the max-finder and any other score consumers:
  - a new_vector_available clear pulse first,
  - then one new_senone strobe per score,
  - last_senone on the final score.
- It sits between the scoring-engine score RAM and the max / pruning stage.

Parameters:
- N_SENONES, 4096, number of senones scored per vector (≥2).
- ADDR_W, 12, score RAM address width (must satisfy 2^ADDR_W ≥ N_SENONES).
- SCORE_W, 16, signed score width (matches num).
- READ_LATENCY, 1, RAM cycles from rd_en/rd_addr to valid rd_data (legal 1..3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request: new vector's scores are ready in RAM
- hold  in  1  back-pressure; while high, no new RAM reads are issued
- rd_en  out  1  score RAM read enable
- rd_addr  out  ADDR_W  score RAM address
- rd_data  in  SCORE_W  score RAM read data, signed
- new_vector_available  out  1  one-cycle clear pulse to consumers
- new_senone  out  1  current_score is valid this cycle
- last_senone  out  1  high with new_senone on the final senone only
- current_score  out  SCORE_W  signed score, passed through unmodified
- senone_index  out  ADDR_W  index of current_score
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last score is emitted

Behaviour:
- Reset is synchronous, active-high, one clock, single clock domain.
- Reset values:
  - all outputs 0; current_score 0; senone_index 0; rd_addr 0;
  - FSM in IDLE; read pipeline valid bits cleared.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: waits for start. start=1 → CLEAR.
  - CLEAR: exactly one cycle. new_vector_available=1, busy=1 → ISSUE with the address counter at 0.
  - ISSUE:
    - Each cycle with hold=0: rd_en=1, rd_addr=counter, counter increments.
    - When hold=1: rd_en=0 and the counter holds.
    - After address N_SENONES-1 is issued → DRAIN.
  - DRAIN: waits until the read pipeline is empty and the last score has been emitted → DONE.
  - DONE: one cycle. done=1, busy drops to 0 in this cycle → IDLE.
- Read pipeline:
  - A shift register READ_LATENCY deep carries a valid bit plus the address.
  - rd_data is captured when the valid bit exits, and registered onto current_score and senone_index with new_senone=1.
- Latency: a read issued in cycle t appears as new_senone in cycle t+READ_LATENCY+1.
- Example timing, READ_LATENCY=1:
  - start in cycle 0; new_vector_available in cycle 1; rd_addr 0 in cycle 2;
  - first new_senone in cycle 4; last in cycle 3+N_SENONES; done in cycle 4+N_SENONES.
- hold:
  - Affects only read issue.
  - Reads already in flight still complete and emit; emitted scores are never dropped or duplicated.
  - With hold continuously 0, new_senone is high on N_SENONES consecutive cycles.
- last_senone is high only in the cycle new_senone carries index N_SENONES-1.
- new_vector_available never coincides with new_senone; at least one idle cycle separates it from the first score.
- start handling:
  - start while busy (CLEAR..DONE) is ignored; no queuing.
  - start in the same cycle as done (DONE state) is ignored.
  - start in the cycle after done begins a new frame normally.
- Counter boundary: no wrap past N_SENONES-1; no read is issued with rd_addr ≥ N_SENONES.
- Reset mid-frame:
  - Immediately returns to IDLE and clears the pipeline valid bits.
  - No further new_senone, last_senone or done pulses from the aborted frame.
- Arithmetic: none on scores. current_score is the bit-exact signed rd_data; 16'h8000 passes through as the most negative value.

Test Plan:
- N_SENONES=4, READ_LATENCY=1, RAM={5,-3,12,7}, start pulse in cycle 0, hold=0 → new_vector_available cycle 1; new_senone cycles 4-7 with scores 5,-3,12,7; last_senone cycle 7 only; done cycle 8; attached max-finder best_score=12.
- Same RAM, hold=1 during cycles 3-5 → same four scores in order, no duplicates; emission gap matches the hold window; last_senone still only on index 3; done one cycle after index 3.
- READ_LATENCY=3, RAM={16'h8000,16'h8001,-1,0} → first new_senone 4 cycles after first rd_en; scores bit-exact including 16'h8000; best_score=0.
- start pulses at cycles 0, 3 and in the done cycle → exactly one frame; busy continuous; a second start the cycle after done produces a second clean frame with its own new_vector_available.
- reset asserted during the cycle after the second new_senone → next cycle all outputs 0, FSM IDLE; no last_senone or done; a following start gives a full correct frame.
- N_SENONES=2 minimum → two new_senone pulses, last_senone on index 1, rd_addr never exceeds 1.
